// File: rtl/lsu_pipelined_pkg.sv
// Shared types and helpers for the pipelined load/store unit.
// ld_align is also used by the single-cycle LSU, so keep its behaviour stable.
package lsu_pipelined_pkg;

  typedef enum logic [2:0] {
    F3_LB  = 3'd0,
    F3_LH  = 3'd1,
    F3_LW  = 3'd2,
    F3_LBU = 3'd4,
    F3_LHU = 3'd5
  } mem_funct3_t;

  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;
  localparam logic [2:0] F3_SW = 3'd2;

  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [1:0] off;
  } ld_entry_t;

  function automatic logic [31:0] ld_align(input logic [31:0] word, input logic [1:0] off,
                                           input logic [2:0] funct3);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (funct3)
      F3_LB:   ld_align = {{24{sh[7]}}, sh[7:0]};
      F3_LH:   ld_align = {{16{sh[15]}}, sh[15:0]};
      F3_LBU:  ld_align = {24'h0, sh[7:0]};
      F3_LHU:  ld_align = {16'h0, sh[15:0]};
      default: ld_align = word;
    endcase
  endfunction

  // Undefined funct3 encodings are folded into the misaligned path.
  function automatic logic op_bad(input logic is_load, input logic [2:0] funct3,
                                  input logic [1:0] off);
    logic bad_f3;
    bad_f3 = is_load ? (funct3 == 3'd3 || funct3[2:1] == 2'b11) : (funct3 >= 3'd3);
    case (funct3[1:0])
      2'b01:   op_bad = bad_f3 | off[0];
      2'b10:   op_bad = bad_f3 | (off != 2'b00);
      default: op_bad = bad_f3;
    endcase
  endfunction

endpackage

// File: rtl/lsu_pipelined_if.sv
// Execute-side request, data-port and writeback signals of the pipelined LSU.
interface lsu_pipelined_if #(parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic              req_is_load;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [4:0]        req_rd;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_we;
  logic [31:0]       mem_wdata;
  logic              mem_rsp_valid;
  logic [31:0]       mem_rsp_data;
  logic              wb_valid;
  logic [4:0]        wb_rd;
  logic [31:0]       wb_data;
  logic [31:0]       pending_rd;
  logic              misalign_err;
  logic              rsp_err;
  logic              busy;

  modport slave (
    input  req_valid, req_is_load, req_funct3, req_addr, req_wdata, req_rd,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output req_ready, mem_req_valid, mem_addr, mem_we, mem_wdata,
    output wb_valid, wb_rd, wb_data, pending_rd, misalign_err, rsp_err, busy
  );

  modport master (
    output req_valid, req_is_load, req_funct3, req_addr, req_wdata, req_rd,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  req_ready, mem_req_valid, mem_addr, mem_we, mem_wdata,
    input  wb_valid, wb_rd, wb_data, pending_rd, misalign_err, rsp_err, busy
  );
endinterface

// File: rtl/lsu_load_queue.sv
// Circular FIFO of outstanding load descriptors, with per-slot visibility
// so the parent can build the pending-destination mask.
module lsu_load_queue
  import lsu_pipelined_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  ld_entry_t                        entry_in,
  input  logic                             pop,
  output ld_entry_t                        head,
  output logic                             full,
  output logic                             empty,
  output logic [DEPTH*$bits(ld_entry_t)-1:0] entries,
  output logic [DEPTH-1:0]                 valid
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = $bits(ld_entry_t);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  ld_entry_t      slots [DEPTH];
  logic [PW-1:0]  wp, rp;
  logic [CW-1:0]  cnt;
  logic           do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  // A full queue refuses pushes even when a pop frees a slot this cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = slots[rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      valid <= '0;
    end else begin
      if (do_pop) begin
        rp        <= nxt(rp);
        valid[rp] <= 1'b0;
      end
      if (do_push) begin
        wp        <= nxt(wp);
        valid[wp] <= 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) slots[wp] <= entry_in;
  end

  always_comb begin
    entries = '0;
    for (int i = 0; i < DEPTH; i++) entries[i*EW +: EW] = slots[i];
  end

endmodule

// File: rtl/lsu_pipelined.sv
// Load/store unit with up to MAX_OUTSTANDING in-order loads in flight and a
// registered writeback stage one cycle after each data response.
module lsu_pipelined
  import lsu_pipelined_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_W          = 32
) (
  input logic             clk,
  input logic             rst,
  lsu_pipelined_if.slave  bus
);
  localparam int EW = $bits(ld_entry_t);

  logic [1:0]  off;
  logic        bad_op, blocked, full, empty, push, pop;
  ld_entry_t   head, entry_in;
  logic [MAX_OUTSTANDING*EW-1:0] entries;
  logic [MAX_OUTSTANDING-1:0]    ent_valid;
  logic        wb_valid_q, misalign_q, rsp_err_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic [31:0] pend;

  assign off     = bus.req_addr[1:0];
  assign bad_op  = op_bad(bus.req_is_load, bus.req_funct3, off);
  assign blocked = bus.req_is_load & full;

  // Bad ops are swallowed locally so execute never stalls on them.
  assign bus.mem_req_valid = bus.req_valid & ~bad_op & ~blocked;
  assign bus.req_ready     = bad_op | (bus.mem_req_ready & ~blocked);
  assign bus.mem_addr      = {bus.req_addr[ADDR_W-1:2], 2'b00};

  assign push     = bus.mem_req_valid & bus.mem_req_ready & bus.req_is_load;
  assign pop      = bus.mem_rsp_valid & ~empty;
  assign entry_in = '{rd: bus.req_rd, funct3: bus.req_funct3, off: off};

  always_comb begin
    bus.mem_we    = 4'b1111;
    bus.mem_wdata = bus.req_wdata;
    case (bus.req_funct3)
      F3_SB: begin
        bus.mem_we    = 4'b0001 << off;
        bus.mem_wdata = {4{bus.req_wdata[7:0]}};
      end
      F3_SH: begin
        bus.mem_we    = 4'b0011 << off;
        bus.mem_wdata = {2{bus.req_wdata[15:0]}};
      end
      default: ;
    endcase
    if (bus.req_is_load) bus.mem_we = 4'b0000;
  end

  lsu_load_queue #(.DEPTH(MAX_OUTSTANDING)) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .entry_in (entry_in),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .entries  (entries),
    .valid    (ent_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      misalign_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      misalign_q <= bus.req_valid & bad_op;
      rsp_err_q  <= bus.mem_rsp_valid & empty;
      wb_valid_q <= pop & (head.rd != 5'd0);
      if (pop) begin
        wb_rd_q   <= head.rd;
        wb_data_q <= ld_align(bus.mem_rsp_data, head.off, head.funct3);
      end
    end
  end

  always_comb begin
    ld_entry_t e;
    pend = '0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      e = entries[i*EW +: EW];
      if (ent_valid[i]) pend[e.rd] = 1'b1;
    end
    if (wb_valid_q) pend[wb_rd_q] = 1'b1;
    pend[0] = 1'b0;
  end

  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_rd        = wb_rd_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.misalign_err = misalign_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.pending_rd   = pend;
  assign bus.busy         = ~empty | wb_valid_q;

endmodule

// File: tb/tb_lsu_pipelined.sv
// Scoreboard bench for lsu_pipelined: a data-port responder with random latency,
// a reference model of queued loads, and a monitor that checks every DUT output event.
module tb_lsu_pipelined;
  localparam int MAXO = 2;
  localparam int AW   = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_pipelined_if #(.ADDR_W(AW)) bus();
  lsu_pipelined #(.MAX_OUTSTANDING(MAXO), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {logic ld; logic [2:0] f3; logic [31:0] addr; logic [31:0] wdata; logic [4:0] rd;} op_t;
  typedef struct {int cyc; logic [4:0] rd; logic [31:0] data;} wb_t;
  typedef struct {logic ld; logic [31:0] addr; logic [3:0] we; logic [31:0] wdata;} memx_t;

  op_t   stim_q[$], pend_q[$];
  wb_t   exp_wb[$];
  memx_t exp_mem[$];
  int    exp_mis[$], exp_rerr[$], rsp_due[$];
  logic [31:0] rsp_force[$];

  int n_vec = 0, n_bad = 0, cyc = 0, n_rerr = 0;
  int dly_min = 1, dly_max = 6;
  bit rand_ready = 1'b0, do_reset = 1'b0, go = 1'b0, have_cur = 1'b0;
  bit wb_stage_v = 1'b0;
  logic [4:0] wb_stage_rd = '0;
  op_t cur;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  function automatic bit is_bad(op_t o);
    case (o.f3)
      3'd0:    return 1'b0;
      3'd1:    return o.addr[0];
      3'd2:    return o.addr[1:0] != 2'b00;
      3'd4, 3'd5: return o.ld ? (o.f3 == 3'd5 && o.addr[0]) : 1'b1;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] ld_expect(op_t o, logic [31:0] w);
    logic [31:0] v, b, h;
    v = w >> (8 * o.addr[1:0]);
    b = v & 32'hFF;
    h = v & 32'hFFFF;
    case (o.f3)
      3'd0:    return (b > 127) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h > 32767) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic memx_t mem_expect(op_t o);
    memx_t m;
    m.ld    = o.ld;
    m.addr  = {o.addr[31:2], 2'b00};
    m.we    = 4'b1111;
    m.wdata = o.wdata;
    if (o.f3 == 3'd0) begin
      m.we = 4'b0001 << o.addr[1:0];
      m.wdata = {4{o.wdata[7:0]}};
    end else if (o.f3 == 3'd1) begin
      m.we = 4'b0011 << o.addr[1:0];
      m.wdata = {2{o.wdata[15:0]}};
    end
    if (o.ld) m.we = 4'b0000;
    return m;
  endfunction

  task automatic add_op(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd);
    op_t o;
    o = '{ld: ld, f3: f3, addr: addr, wdata: wdata, rd: rd};
    stim_q.push_back(o);
  endtask

  // Driver plus reference model: one iteration per clock, inputs change on the falling edge.
  initial begin : driver
    bit rsp_now, acc, bad, exp_rdy;
    logic [31:0] rdata, exp_pend;
    int pre_size;
    op_t o;
    bus.req_valid = 0; bus.req_is_load = 0; bus.req_funct3 = 0; bus.req_addr = 0;
    bus.req_wdata = 0; bus.req_rd = 0; bus.mem_req_ready = 0; bus.mem_rsp_valid = 0;
    bus.mem_rsp_data = 0;
    wait (go);
    forever begin
      @(negedge clk);
      if (do_reset) begin
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        have_cur = 1'b0;
        wb_stage_v = 1'b0;
        pend_q.delete(); exp_wb.delete(); exp_mis.delete(); exp_mem.delete();
        do_reset = 1'b0;
        continue;
      end
      rst = 1'b0;
      rsp_now = (rsp_due.size() > 0) && (rsp_due[0] <= cyc);
      rdata = $urandom;
      if (rsp_now) begin
        void'(rsp_due.pop_front());
        if (rsp_force.size() > 0) rdata = rsp_force.pop_front();
      end
      bus.mem_rsp_valid = rsp_now;
      bus.mem_rsp_data  = rdata;
      bus.mem_req_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (!have_cur && stim_q.size() > 0 && (!rand_ready || $urandom_range(0, 3) != 0)) begin
        cur = stim_q.pop_front();
        have_cur = 1'b1;
      end
      bus.req_valid   = have_cur;
      bus.req_is_load = cur.ld;
      bus.req_funct3  = cur.f3;
      bus.req_addr    = cur.addr;
      bus.req_wdata   = cur.wdata;
      bus.req_rd      = cur.rd;
      #1;
      exp_pend = '0;
      foreach (pend_q[i]) exp_pend[pend_q[i].rd] = 1'b1;
      if (wb_stage_v) exp_pend[wb_stage_rd] = 1'b1;
      exp_pend[0] = 1'b0;
      check("pending_rd", bus.pending_rd, exp_pend);
      check("busy", bus.busy, (pend_q.size() > 0) || wb_stage_v);
      pre_size = pend_q.size();
      acc = 1'b0;
      bad = 1'b0;
      if (have_cur) begin
        bad = is_bad(cur);
        exp_rdy = bad ? 1'b1 : ((cur.ld && pre_size == MAXO) ? 1'b0 : bus.mem_req_ready);
        check("req_ready", bus.req_ready, exp_rdy);
        acc = exp_rdy;
      end
      // The pop is modelled before this cycle's push so an empty-queue response stays an error.
      wb_stage_v = 1'b0;
      if (rsp_now) begin
        if (pend_q.size() == 0) exp_rerr.push_back(cyc + 1);
        else begin
          o = pend_q.pop_front();
          if (o.rd != 5'd0) begin
            exp_wb.push_back('{cyc: cyc + 1, rd: o.rd, data: ld_expect(o, rdata)});
            wb_stage_v  = 1'b1;
            wb_stage_rd = o.rd;
          end
        end
      end
      if (acc) begin
        if (bad) exp_mis.push_back(cyc + 1);
        else begin
          exp_mem.push_back(mem_expect(cur));
          if (cur.ld) pend_q.push_back(cur);
        end
        have_cur = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents an event.
  initial begin : monitor
    memx_t m;
    wb_t w;
    forever begin
      @(negedge clk);
      #2;
      if (rst || !go) continue;
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        if (exp_mem.size() == 0) fail("mem_req_unexpected");
        else begin
          m = exp_mem.pop_front();
          check("mem_addr", bus.mem_addr, m.addr);
          check("mem_we", {28'h0, bus.mem_we}, {28'h0, m.we});
          if (!m.ld) check("mem_wdata", bus.mem_wdata, m.wdata);
          else rsp_due.push_back(cyc + $urandom_range(dly_min, dly_max));
        end
      end
      if (bus.wb_valid) begin
        if (exp_wb.size() == 0) fail("wb_unexpected");
        else begin
          w = exp_wb.pop_front();
          check("wb_cycle", cyc, w.cyc);
          check("wb_rd", {27'h0, bus.wb_rd}, {27'h0, w.rd});
          check("wb_data", bus.wb_data, w.data);
        end
      end
      while (exp_wb.size() > 0 && exp_wb[0].cyc < cyc) begin
        fail("wb_missing");
        void'(exp_wb.pop_front());
      end
      if (bus.misalign_err) begin
        if (exp_mis.size() == 0) fail("misalign_unexpected");
        else check("misalign_cycle", cyc, exp_mis.pop_front());
      end
      while (exp_mis.size() > 0 && exp_mis[0] < cyc) begin
        fail("misalign_missing");
        void'(exp_mis.pop_front());
      end
      if (bus.rsp_err) begin
        n_rerr++;
        if (exp_rerr.size() == 0) fail("rsp_err_unexpected");
        else check("rsp_err_cycle", cyc, exp_rerr.pop_front());
      end
      while (exp_rerr.size() > 0 && exp_rerr[0] < cyc) begin
        fail("rsp_err_missing");
        void'(exp_rerr.pop_front());
      end
    end
  end

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((stim_q.size() > 0 || have_cur || pend_q.size() > 0 || rsp_due.size() > 0 ||
            exp_wb.size() > 0 || exp_mis.size() > 0 || exp_rerr.size() > 0 ||
            exp_mem.size() > 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) fail("drain_timeout");
    repeat (3) @(posedge clk);
  endtask

  initial begin : control
    int n;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_wb_valid", bus.wb_valid, 1'b0);
    check("reset_wb_rd", {27'h0, bus.wb_rd}, 32'h0);
    check("reset_wb_data", bus.wb_data, 32'h0);
    check("reset_misalign", bus.misalign_err, 1'b0);
    check("reset_rsp_err", bus.rsp_err, 1'b0);
    check("reset_pending", bus.pending_rd, 32'h0);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_mem_req_valid", bus.mem_req_valid, 1'b0);
    go = 1'b1;

    dly_min = 1; dly_max = 1;
    rsp_force.push_back(32'hDEAD_BEEF);
    add_op(1, 3'd2, 32'h100, 32'h0, 5'd5);
    wait_drain(200);

    rsp_force.push_back(32'h80FF_FFFF);
    rsp_force.push_back(32'h80FF_FFFF);
    rsp_force.push_back(32'h1234_5678);
    add_op(1, 3'd0, 32'h103, 32'h0, 5'd6);
    add_op(1, 3'd4, 32'h103, 32'h0, 5'd7);
    add_op(1, 3'd5, 32'h102, 32'h0, 5'd8);
    wait_drain(200);

    add_op(0, 3'd0, 32'h201, 32'h0000_00AB, 5'd0);
    add_op(0, 3'd1, 32'h203, 32'h0000_CAFE, 5'd0);
    wait_drain(200);

    dly_min = 5; dly_max = 5;
    add_op(1, 3'd2, 32'h10, 32'h0, 5'd1);
    add_op(1, 3'd2, 32'h14, 32'h0, 5'd2);
    add_op(1, 3'd2, 32'h18, 32'h0, 5'd3);
    wait_drain(300);

    dly_min = 2; dly_max = 4;
    add_op(1, 3'd2, 32'h20, 32'h0, 5'd7);
    add_op(1, 3'd1, 32'h22, 32'h0, 5'd7);
    add_op(1, 3'd2, 32'h24, 32'h0, 5'd0);
    wait_drain(300);

    dly_min = 8; dly_max = 8;
    n_rerr = 0;
    add_op(1, 3'd2, 32'h30, 32'h0, 5'd9);
    add_op(1, 3'd2, 32'h34, 32'h0, 5'd10);
    n = 0;
    while (pend_q.size() < 2 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (n >= 100) fail("reset_setup_timeout");
    do_reset = 1'b1;
    n = 0;
    while (do_reset && n < 20) begin
      @(posedge clk);
      n++;
    end
    wait_drain(300);
    check("reset_rsp_err_count", n_rerr, 2);

    dly_min = 1; dly_max = 6;
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++)
      add_op($urandom_range(0, 1), 3'($urandom_range(0, 7)),
             {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))},
             $urandom, 5'($urandom_range(0, 7)));
    wait_drain(5000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
